rs422_frame_router: RTL and testbench
=====================================

Name: rs422_frame_router

Overview:
- Parametrised successor of the one-hot command demux between the RS422 byte receiver and the per-function channel FIFOs (TC/HK/SD/DI/PF and future channels).
- Latches a one-hot channel select at frame start and forwards bytes through a registered valid/ready stage to the selected channel.
- Enforces frame length and discards frames with an illegal select.
- Waits for the channel's done indication before reporting frame completion upstream.

Parameters:
NUM_CH, 5, number of destination channels (one-hot select width)
DW, 8, data width
MAX_LEN, 256, maximum bytes per frame
CNT_W, 9, width of byte counter (must hold MAX_LEN)
TIMEOUT_CYC, 100000, idle cycles before frame abort (used only with optional feature)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
sof  in  1  frame-start pulse; cmd sampled this cycle
cmd  in  NUM_CH  one-hot channel select
in_valid  in  1  upstream byte valid
in_data  in  DW  upstream byte
in_last  in  1  marks final byte of frame
in_ready  out  1  upstream may transfer
ch_valid  out  NUM_CH  per-channel valid; only bit sel can be high
ch_data  out  DW  shared data bus to channels
ch_ready  in  NUM_CH  per-channel ready (inverse of FIFO full)
ch_done  in  NUM_CH  per-channel frame-consumed pulse
sel  out  NUM_CH  latched select; 0 when idle
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse, frame delivered and acknowledged
frame_err  out  1  one-cycle pulse on any frame error
err_cnt  out  8  saturating error counter

Behaviour:
- Reset (async): state IDLE; sel=0; ch_valid=0; ch_data=0; in_ready=0; busy=0; frame_done=0; frame_err=0; err_cnt=0; byte counter=0.
- Transfer occurs on in_valid&in_ready (upstream) and ch_valid[sel]&ch_ready[sel] (downstream).
- States: IDLE, ROUTE, DISCARD, FLUSH, WAIT_DONE.
- IDLE:
  - in_ready=0.
  - sof with cmd exactly one-hot: sel<=cmd, counter<=0, go to ROUTE.
  - sof with cmd zero or multi-hot: go to DISCARD, frame_err pulse, err_cnt++.
- ROUTE:
  - One-entry output register; in_ready = !hold | ch_ready[sel].
  - A byte accepted at cycle t drives ch_valid[sel]/ch_data at t+1.
  - Simultaneous drain and fill are allowed, giving full throughput of 1 byte/cycle.
  - The counter increments per accepted byte.
  - Accepted byte with in_last, or the MAX_LEN-th byte: go to FLUSH.
  - The MAX_LEN-th byte without in_last additionally pulses frame_err and increments err_cnt.
- DISCARD: in_ready=1; bytes are dropped; accepted byte with in_last returns to IDLE.
- FLUSH: in_ready=0; when the output register empties, go to WAIT_DONE.
- WAIT_DONE: on ch_done[sel], pulse frame_done next cycle, then IDLE with sel=0. ch_done on other bits is ignored.
- sof outside IDLE is ignored, pulses frame_err and increments err_cnt. The current frame continues.
- err_cnt saturates at 255.
- ch_data holds its last value when ch_valid=0.
- Reset mid-frame: immediate return to reset values. A partially delivered frame is not completed.

Optional Feature:
- Macro: ROUTER_TIMEOUT_EN.
- With the macro defined:
  - An idle counter runs in ROUTE/DISCARD and clears on every upstream transfer.
  - Reaching TIMEOUT_CYC aborts the frame: the output register is cleared, frame_err pulses, err_cnt++, and the state returns to IDLE without frame_done.
- Without the macro: no counter; ROUTE/DISCARD wait indefinitely; TIMEOUT_CYC is unused.

Decomposition:
- Shared package rs422_pkg holds:
  - the state enum;
  - default constants NUM_CH=5, DW=8;
  - channel index constants CH_TC=0, CH_HK=1, CH_SD=2, CH_DI=3, CH_PF=4;
  - an is_onehot function.
- One sub-module, rs422_skid_reg: the one-entry valid/ready output register. Its interface is in_valid/in_ready/out_valid/out_ready/data.

Test Plan:
- sof with cmd=5'b00100, then 4 bytes 0x11..0x14 with in_last on 0x14, ch_ready=all 1 -> ch_valid=5'b00100 with bytes in order, each one cycle after acceptance. ch_done[2] pulse -> frame_done one cycle later, sel=0.
- Same frame with ch_ready[2] low for 3 cycles after the 2nd byte -> in_ready drops, no byte lost or duplicated, and ordering is kept.
- sof with cmd=5'b00110, then 3 bytes with last -> frame_err pulse, err_cnt=1, all ch_valid=0, in_ready=1 throughout, then IDLE.
- MAX_LEN=4: 6 bytes with no in_last -> exactly 4 delivered, frame_err pulse, in_ready=0 after the 4th byte.
- sof during ROUTE -> ignored, err_cnt increments, and the current frame completes normally.
- ROUTER_TIMEOUT_EN, TIMEOUT_CYC=10: stall input for 10 cycles mid-frame -> frame_err pulse, no frame_done, busy=0; a later sof is accepted.

Source files
------------

// File: rtl/rs422_pkg.sv
// Shared types and constants for the RS422 frame router: FSM state encoding,
// default widths, channel indices and a one-hot test.
package rs422_pkg;

    localparam int DEF_NUM_CH = 5;
    localparam int DEF_DW     = 8;
    localparam int MAX_CH     = 32;

    localparam int CH_TC = 0;
    localparam int CH_HK = 1;
    localparam int CH_SD = 2;
    localparam int CH_DI = 3;
    localparam int CH_PF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROUTE,
        ST_DISCARD,
        ST_FLUSH,
        ST_WAIT_DONE
    } router_state_e;

    // Select vectors narrower than MAX_CH are zero-extended by the caller.
    function automatic logic is_onehot(input logic [MAX_CH-1:0] v);
        return (v != '0) && ((v & (v - MAX_CH'(1))) == '0);
    endfunction

endpackage

// File: rtl/rs422_skid_reg.sv
// One-entry valid/ready output register; accepts a new word in the same cycle
// the held word drains, so it sustains one word per cycle.
module rs422_skid_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // out_data is only loaded on a fill, so it holds while out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rs422_frame_router.sv
// Routes RS422 command frames to one of NUM_CH channel FIFOs by a one-hot select.
// Optional idle-timeout abort is built when ROUTER_TIMEOUT_EN is defined.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | no frame; waiting for sof
// ST_ROUTE     | forwarding bytes to channel sel
// ST_DISCARD   | illegal select; dropping bytes until in_last
// ST_FLUSH     | frame fully accepted; draining the output register
// ST_WAIT_DONE | waiting for ch_done[sel] before reporting frame_done
module rs422_frame_router
    import rs422_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DW          = DEF_DW,
    parameter int MAX_LEN     = 256,
    parameter int CNT_W       = 9,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sof,
    input  logic [NUM_CH-1:0] cmd,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [NUM_CH-1:0] ch_valid,
    output logic [DW-1:0]     ch_data,
    input  logic [NUM_CH-1:0] ch_ready,
    input  logic [NUM_CH-1:0] ch_done,
    output logic [NUM_CH-1:0] sel,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        err_cnt
);

    router_state_e state, state_n;

    logic [CNT_W-1:0] byte_cnt;
    logic             skid_in_valid;
    logic             skid_in_ready;
    logic             skid_valid;
    logic             skid_out_ready;
    logic             up_xfer;
    logic             load_sel;
    logic             err_evt;
    logic             done_evt;
    logic             abort;
    logic             timeout_hit;
    logic             last_slot;

    assign up_xfer        = in_valid && in_ready;
    assign last_slot      = (byte_cnt == CNT_W'(MAX_LEN - 1));
    assign skid_in_valid  = in_valid && (state == ST_ROUTE);
    assign skid_out_ready = |(ch_ready & sel);
    assign ch_valid       = sel & {NUM_CH{skid_valid}};
    assign busy           = (state != ST_IDLE);

    rs422_skid_reg #(.DW(DW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clr       (abort),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .in_data   (in_data),
        .out_valid (skid_valid),
        .out_ready (skid_out_ready),
        .out_data  (ch_data)
    );

`ifdef ROUTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_cnt;
    logic            to_active;

    assign to_active   = (state == ST_ROUTE) || (state == ST_DISCARD);
    assign timeout_hit = to_active && !up_xfer && (idle_cnt == '0);

    // Down-counter reloaded on every transfer; terminal count on the
    // TIMEOUT_CYC-th consecutive idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= TO_W'(TIMEOUT_CYC - 1);
        end else if (!to_active || up_xfer) begin
            idle_cnt <= TO_W'(TIMEOUT_CYC - 1);
        end else if (idle_cnt != '0) begin
            idle_cnt <= idle_cnt - TO_W'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        load_sel = 1'b0;
        err_evt  = 1'b0;
        done_evt = 1'b0;
        abort    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sof) begin
                    if (is_onehot(MAX_CH'(cmd))) begin
                        load_sel = 1'b1;
                        state_n  = ST_ROUTE;
                    end else begin
                        err_evt = 1'b1;
                        state_n = ST_DISCARD;
                    end
                end
            end
            ST_ROUTE: begin
                in_ready = skid_in_ready;
                if (in_valid && skid_in_ready && (in_last || last_slot)) begin
                    state_n = ST_FLUSH;
                    if (!in_last) err_evt = 1'b1;
                end
            end
            ST_DISCARD: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_n = ST_IDLE;
            end
            ST_FLUSH: begin
                if (!skid_valid) state_n = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (|(ch_done & sel)) begin
                    done_evt = 1'b1;
                    state_n  = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (sof && (state != ST_IDLE)) err_evt = 1'b1;
        if (timeout_hit) begin
            abort   = 1'b1;
            err_evt = 1'b1;
            state_n = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel        <= '0;
            byte_cnt   <= '0;
            err_cnt    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= done_evt;
            frame_err  <= err_evt;
            if (err_evt && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            if (load_sel) begin
                sel      <= cmd;
                byte_cnt <= '0;
            end else if (state_n == ST_IDLE) begin
                sel <= '0;
            end
            if ((state == ST_ROUTE) && up_xfer) byte_cnt <= byte_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rs422_frame_router.sv
// Randomized scoreboard bench for rs422_frame_router; the timeout scenario is
// exercised only when ROUTER_TIMEOUT_EN is defined.
module tb_rs422_frame_router;

    localparam int NUM_CH      = 5;
    localparam int DW          = 8;
    localparam int MAX_LEN     = 4;
    localparam int CNT_W       = 3;
    localparam int TIMEOUT_CYC = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              sof;
    logic [NUM_CH-1:0] cmd;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_last;
    logic              in_ready;
    logic [NUM_CH-1:0] ch_valid;
    logic [DW-1:0]     ch_data;
    logic [NUM_CH-1:0] ch_ready;
    logic [NUM_CH-1:0] ch_done;
    logic [NUM_CH-1:0] sel;
    logic              busy;
    logic              frame_done;
    logic              frame_err;
    logic [7:0]        err_cnt;

    rs422_frame_router #(
        .NUM_CH(NUM_CH), .DW(DW), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .sof(sof), .cmd(cmd),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready), .ch_done(ch_done),
        .sel(sel), .busy(busy), .frame_done(frame_done), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_err  = 0;
    int exp_done = 0;
    int err_seen = 0;
    int done_seen = 0;
    int ready_mode = 0;
    logic [NUM_CH-1:0] force_ready = '1;
    logic [NUM_CH+DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    function automatic int sat_err();
        return (exp_err > 255) ? 255 : exp_err;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream readiness: 0 = always ready, 1 = random, 2 = forced pattern.
    initial begin
        ch_ready = '1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       ch_ready = '1;
                1:       ch_ready = NUM_CH'($urandom) | NUM_CH'($urandom);
                default: ch_ready = force_ready;
            endcase
        end
    end

    // Monitor: every downstream transfer pops the scoreboard.
    initial begin
        logic [NUM_CH+DW-1:0] exp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (frame_err)  err_seen++;
                if (frame_done) done_seen++;
                if ((ch_valid & ch_ready) != '0) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL byte: unexpected ch_valid=0x%0h data=0x%0h, none required", ch_valid, ch_data);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("byte", {ch_valid, ch_data}, exp);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got %0d checks required finish", n_checks);
        $fatal(1);
    end

    task automatic pulse_sof(input logic [NUM_CH-1:0] c);
        sof = 1'b1;
        cmd = c;
        tick();
        sof = 1'b0;
        cmd = '0;
    endtask

    task automatic send_byte(input logic [DW-1:0] d, input logic last, output logic acc);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        acc      = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("FAIL send_byte: in_ready stayed 0 for byte 0x%0h, required 1", d);
        end
    endtask

    task automatic route_frame(input int ch, input int n, input bit with_last,
                               input bit sof_mid, input bit stall2, input int base);
        logic [NUM_CH-1:0] oh;
        logic [DW-1:0]     d;
        logic              acc;
        logic              last;
        int                other;
        oh = NUM_CH'(1 << ch);
        pulse_sof(oh);
        chk("sel_latched", sel, oh);
        chk("busy_route", busy, 1);
        for (int i = 0; i < n; i++) begin
            if (i >= MAX_LEN) begin
                in_valid = 1'b1;
                in_data  = DW'($urandom);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("in_ready_after_max", in_ready, 0);
                    tick();
                end
                in_valid = 1'b0;
                break;
            end
            d    = (base >= 0) ? DW'(base + i) : DW'($urandom);
            last = with_last && (i == n - 1);
            send_byte(d, last, acc);
            if (acc) exp_q.push_back({oh, d});
            if (i == MAX_LEN - 1 && !last) begin
                exp_err++;
                @(negedge clk);
                chk("overflow_err_pulse", frame_err, 1);
                tick();
            end
            if (stall2 && i == 1) begin
                force_ready = ~oh;
                ready_mode  = 2;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    tick();
                end
                ready_mode = 0;
            end
            if (sof_mid && i == 0 && n > 1) begin
                pulse_sof(NUM_CH'($urandom));
                exp_err++;
                @(negedge clk);
                chk("sof_in_route_err", frame_err, 1);
                chk("sof_in_route_sel", sel, oh);
                tick();
            end
            repeat ($urandom_range(2)) tick();
        end
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) tick();
        chk("frame_drained", exp_q.size(), 0);
        repeat (3) tick();
        other = (ch + 1) % NUM_CH;
        ch_done = NUM_CH'(1 << other);
        tick();
        ch_done = '0;
        @(negedge clk);
        chk("done_ignores_other", frame_done, 0);
        chk("busy_wait_done", busy, 1);
        tick();
        ch_done = oh;
        tick();
        ch_done = '0;
        exp_done++;
        @(negedge clk);
        chk("frame_done_pulse", frame_done, 1);
        chk("sel_cleared", sel, 0);
        chk("idle_not_busy", busy, 0);
        tick();
        chk("err_cnt", err_cnt, sat_err());
    endtask

    task automatic discard_frame(input logic [NUM_CH-1:0] c, input int n);
        pulse_sof(c);
        exp_err++;
        @(negedge clk);
        chk("bad_cmd_err_pulse", frame_err, 1);
        chk("discard_busy", busy, 1);
        tick();
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            in_last  = (i == n - 1);
            @(negedge clk);
            chk("discard_in_ready", in_ready, 1);
            chk("discard_ch_valid", ch_valid, 0);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("discard_back_idle", busy, 0);
        tick();
        chk("err_cnt_discard", err_cnt, sat_err());
    endtask

    initial begin
        logic [NUM_CH-1:0] c;
        logic acc;
        rst = 1'b1; sof = 1'b0; cmd = '0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; ch_done = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ch_valid", ch_valid, 0);
        chk("rst_ch_data", ch_data, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        route_frame(2, 4, 1, 0, 0, 'h11);
        route_frame(2, 4, 1, 0, 1, 'h11);
        discard_frame(5'b00110, 3);
        route_frame(1, 6, 0, 0, 0, -1);
        route_frame(3, 4, 1, 1, 0, -1);

`ifdef ROUTER_TIMEOUT_EN
        ready_mode = 0;
        pulse_sof(5'b00001);
        send_byte(8'hA5, 1'b0, acc);
        if (acc) exp_q.push_back({5'b00001, 8'hA5});
        exp_err++;
        repeat (TIMEOUT_CYC - 1) tick();
        @(negedge clk);
        chk("timeout_still_busy", busy, 1);
        tick();
        @(negedge clk);
        chk("timeout_err_pulse", frame_err, 1);
        chk("timeout_no_done", frame_done, 0);
        chk("timeout_busy", busy, 0);
        tick();
        route_frame(4, 3, 1, 0, 0, -1);
`endif

        ready_mode = 1;
        for (int f = 0; f < 24; f++) begin
            if ($urandom_range(3) == 0) begin
                do c = NUM_CH'($urandom); while ($countones(c) == 1);
                discard_frame(c, $urandom_range(1, 6));
            end else if ($urandom_range(9) == 0) begin
                route_frame($urandom_range(NUM_CH - 1), MAX_LEN + 2, 0, 0, 0, -1);
            end else begin
                route_frame($urandom_range(NUM_CH - 1), $urandom_range(1, MAX_LEN), 1,
                            ($urandom_range(4) == 0), 0, -1);
            end
        end
        ready_mode = 0;

        for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
        repeat (2) tick();
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_err_cnt", err_cnt, sat_err());
        chk("final_err_pulses", err_seen, exp_err);
        chk("final_done_pulses", done_seen, exp_done);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
